// File: rtl/mips_top_pkg.sv
// Shared definitions for the five-stage MIPS-subset core:
// opcodes, functs, special words, ALU ops, stage bundles, decoder.
package mips_top_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        beq;
        logic        bne;
        logic        jump;
        logic        halt;
        logic        use_rs;
        logic        use_rt;
        logic [4:0]  dest;
        logic [31:0] imm;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } if_id_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        ctrl_t       c;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        halt;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
    } mem_wb_t;

    // Unknown opcodes/functs fall through with every enable low (NOP).
    // A non-writing instruction always carries dest=0, so hazard and
    // forwarding logic only need to test dest.
    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        logic [31:0] sext;
        logic [31:0] zext;
        sext = {{16{ins[15]}}, ins[15:0]};
        zext = {16'h0000, ins[15:0]};
        c = '0;
        if (ins == HALT_WORD) begin
            c.halt = 1'b1;
        end else begin
            case (ins[31:26])
                OP_RTYPE: begin
                    c.reg_write = 1'b1;
                    c.use_rs    = 1'b1;
                    c.use_rt    = 1'b1;
                    c.dest      = ins[15:11];
                    case (ins[5:0])
                        F_ADDU: c.alu_op = ALU_ADD;
                        F_SUBU: c.alu_op = ALU_SUB;
                        F_AND:  c.alu_op = ALU_AND;
                        F_OR:   c.alu_op = ALU_OR;
                        F_XOR:  c.alu_op = ALU_XOR;
                        F_SLT:  c.alu_op = ALU_SLT;
                        F_SLL: begin
                            c.alu_op = ALU_SLL;
                            c.use_rs = 1'b0;
                        end
                        F_SRL: begin
                            c.alu_op = ALU_SRL;
                            c.use_rs = 1'b0;
                        end
                        default: begin
                            c.reg_write = 1'b0;
                            c.use_rs    = 1'b0;
                            c.use_rt    = 1'b0;
                        end
                    endcase
                end
                OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                    c.use_imm   = 1'b1;
                    c.reg_write = 1'b1;
                    c.use_rs    = (ins[31:26] != OP_LUI);
                    c.dest      = ins[20:16];
                    c.mem_read  = (ins[31:26] == OP_LW);
                    c.imm       = sext;
                    case (ins[31:26])
                        OP_SLTI: c.alu_op = ALU_SLT;
                        OP_ANDI: begin
                            c.alu_op = ALU_AND;
                            c.imm    = zext;
                        end
                        OP_ORI: begin
                            c.alu_op = ALU_OR;
                            c.imm    = zext;
                        end
                        OP_XORI: begin
                            c.alu_op = ALU_XOR;
                            c.imm    = zext;
                        end
                        OP_LUI: begin
                            c.alu_op = ALU_LUI;
                            c.imm    = zext;
                        end
                        default: c.alu_op = ALU_ADD;
                    endcase
                end
                OP_SW: begin
                    c.use_imm   = 1'b1;
                    c.mem_write = 1'b1;
                    c.use_rs    = 1'b1;
                    c.use_rt    = 1'b1;
                    c.imm       = sext;
                end
                OP_BEQ, OP_BNE: begin
                    c.beq    = (ins[31:26] == OP_BEQ);
                    c.bne    = (ins[31:26] == OP_BNE);
                    c.use_rs = 1'b1;
                    c.use_rt = 1'b1;
                    c.imm    = sext;
                end
                OP_J: c.jump = 1'b1;
                default: c = '0;
            endcase
        end
        if (c.dest == 5'd0) begin
            c.reg_write = 1'b0;
        end
        if (!c.reg_write) begin
            c.dest = 5'd0;
        end
        return c;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU.
// Ports: a, b operands; shamt for SLL/SRL (shifts b); op; y result.
module mips_alu
    import mips_top_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_e     op,
    output logic [31:0] y
);

    always_comb begin
        y = a + b;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLL: y = b << shamt;
            ALU_SRL: y = b >> shamt;
            ALU_LUI: y = {b[15:0], 16'h0000};
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file, two read ports with write-through, one write port.
// Ports: clk, reset (async low), we/waddr/wdata, ra1/ra2 -> rd1/rd2, dbg read.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [32];
    logic        wr_ok;

    // $0 is never written, so it reads as zero without a special case.
    assign wr_ok = we && (waddr != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd1 = (wr_ok && waddr == ra1) ? wdata : regs[ra1];
    assign rd2 = (wr_ok && waddr == ra2) ? wdata : regs[ra2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/mips_top.sv
// Five-stage MIPS-subset core with inline IMEM (64w) and DMEM (32w).
// Ports: clk/reset, debug freeze + IMEM load, debug reads, PC/latch/halt taps.
module mips_top
    import mips_top_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        debug_flag,
    input  logic [31:0] in_addr_debug,
    input  logic [31:0] in_addr_mem_inst,
    input  logic [31:0] in_ins_to_mem,
    input  logic        wea_ram_inst,
    output logic [31:0] out_reg1_recolector,
    output logic [31:0] out_mem_wire,
    output logic [31:0] out_pc,
    output logic        halt_flag,
    output logic [31:0] Latches_1_2,
    output logic [31:0] Latches_2_3,
    output logic [31:0] Latches_3_4,
    output logic [31:0] Latches_4_5
);

    logic [31:0] imem [64];
    logic [31:0] dmem [32];

    logic [31:0] pc;
    if_id_t      if_id;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    logic        advance;
    ctrl_t       id_c;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        load_use;
    logic        halt_stop;
    logic [31:0] jump_target;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] wb_data;
    logic        unused_ok;

    assign advance = !halt_flag && !debug_flag;

    // ID
    assign id_c = decode(if_id.ins);

    mips_regfile u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (advance && mem_wb.rw),
        .waddr    (mem_wb.dest),
        .wdata    (mem_wb.data),
        .ra1      (if_id.ins[25:21]),
        .ra2      (if_id.ins[20:16]),
        .rd1      (rs_val),
        .rd2      (rt_val),
        .dbg_addr (in_addr_debug[4:0]),
        .dbg_data (out_reg1_recolector)
    );

    assign load_use = id_ex.c.mem_read && (id_ex.c.dest != 5'd0) &&
        ((id_c.use_rs && if_id.ins[25:21] == id_ex.c.dest) ||
         (id_c.use_rt && if_id.ins[20:16] == id_ex.c.dest));

    // Fetch stays stopped from HALT decode until halt_flag takes over.
    assign halt_stop = id_c.halt || id_ex.c.halt || ex_mem.halt;

    assign jump_target = {if_id.pc4[31:28], if_id.ins[25:0], 2'b00};

    // EX
    always_comb begin
        fwd_a = id_ex.a;
        if (ex_mem.rw && ex_mem.dest == id_ex.ins[25:21]) begin
            fwd_a = ex_mem.alu;
        end else if (mem_wb.rw && mem_wb.dest == id_ex.ins[25:21]) begin
            fwd_a = mem_wb.data;
        end
    end

    always_comb begin
        fwd_b = id_ex.b;
        if (ex_mem.rw && ex_mem.dest == id_ex.ins[20:16]) begin
            fwd_b = ex_mem.alu;
        end else if (mem_wb.rw && mem_wb.dest == id_ex.ins[20:16]) begin
            fwd_b = mem_wb.data;
        end
    end

    assign alu_b = id_ex.c.use_imm ? id_ex.c.imm : fwd_b;

    mips_alu u_alu (
        .a     (fwd_a),
        .b     (alu_b),
        .shamt (id_ex.ins[10:6]),
        .op    (id_ex.c.alu_op),
        .y     (alu_y)
    );

    assign branch_taken = (id_ex.c.beq && fwd_a == fwd_b) ||
                          (id_ex.c.bne && fwd_a != fwd_b);
    assign branch_target = id_ex.pc4 + {id_ex.c.imm[29:0], 2'b00};

    // MEM
    assign wb_data = ex_mem.mr ? dmem[ex_mem.alu[6:2]] : ex_mem.alu;

    always_ff @(posedge clk) begin
        if (advance && ex_mem.mw) begin
            dmem[ex_mem.alu[6:2]] <= ex_mem.st;
        end
    end

    always_ff @(posedge clk) begin
        if (debug_flag && wea_ram_inst) begin
            imem[in_addr_mem_inst[7:2]] <= in_ins_to_mem;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= 32'h0;
            if_id     <= '0;
            id_ex     <= '0;
            ex_mem    <= '0;
            mem_wb    <= '0;
            halt_flag <= 1'b0;
        end else if (advance) begin
            if (ex_mem.halt) begin
                halt_flag <= 1'b1;
            end
            mem_wb.data <= wb_data;
            mem_wb.dest <= ex_mem.dest;
            mem_wb.rw   <= ex_mem.rw;

            ex_mem.alu  <= alu_y;
            ex_mem.st   <= fwd_b;
            ex_mem.dest <= id_ex.c.dest;
            ex_mem.rw   <= id_ex.c.reg_write;
            ex_mem.mr   <= id_ex.c.mem_read;
            ex_mem.mw   <= id_ex.c.mem_write;
            ex_mem.halt <= id_ex.c.halt;

            if (load_use || branch_taken) begin
                id_ex <= '0;
            end else begin
                id_ex.ins <= if_id.ins;
                id_ex.pc4 <= if_id.pc4;
                id_ex.a   <= rs_val;
                id_ex.b   <= rt_val;
                id_ex.c   <= id_c;
            end

            if (load_use) begin
                pc    <= pc;
                if_id <= if_id;
            end else if (branch_taken) begin
                pc    <= branch_target;
                if_id <= '0;
            end else if (halt_stop) begin
                pc    <= pc;
                if_id <= '0;
            end else if (id_c.jump) begin
                pc    <= jump_target;
                if_id <= '0;
            end else begin
                pc        <= pc + 32'd4;
                if_id.ins <= imem[pc[7:2]];
                if_id.pc4 <= pc + 32'd4;
            end
        end
    end

    assign out_mem_wire = dmem[in_addr_debug[4:0]];
    assign out_pc       = pc;
    assign Latches_1_2  = if_id.ins;
    assign Latches_2_3  = id_ex.ins;
    assign Latches_3_4  = ex_mem.alu;
    assign Latches_4_5  = mem_wb.data;

    assign unused_ok = ^{in_addr_debug[31:5], in_addr_mem_inst[31:8],
                         in_addr_mem_inst[1:0], id_ex.c.jump,
                         id_ex.c.use_rs, id_ex.c.use_rt, NOP_WORD};

endmodule

// File: tb/tb_mips_top.sv
// Directed bench for mips_top: reset, forwarding, load-use, branch,
// ALU table, debug freeze and mid-run reset.
module tb_mips_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        debug_flag;
    logic [31:0] in_addr_debug;
    logic [31:0] in_addr_mem_inst;
    logic [31:0] in_ins_to_mem;
    logic        wea_ram_inst;
    logic [31:0] out_reg1_recolector;
    logic [31:0] out_mem_wire;
    logic [31:0] out_pc;
    logic        halt_flag;
    logic [31:0] Latches_1_2;
    logic [31:0] Latches_2_3;
    logic [31:0] Latches_3_4;
    logic [31:0] Latches_4_5;

    mips_top dut (
        .clk                 (clk),
        .reset               (reset),
        .debug_flag          (debug_flag),
        .in_addr_debug       (in_addr_debug),
        .in_addr_mem_inst    (in_addr_mem_inst),
        .in_ins_to_mem       (in_ins_to_mem),
        .wea_ram_inst        (wea_ram_inst),
        .out_reg1_recolector (out_reg1_recolector),
        .out_mem_wire        (out_mem_wire),
        .out_pc              (out_pc),
        .halt_flag           (halt_flag),
        .Latches_1_2         (Latches_1_2),
        .Latches_2_3         (Latches_2_3),
        .Latches_3_4         (Latches_3_4),
        .Latches_4_5         (Latches_4_5)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } reg_vec_t;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] prog [64];
    reg_vec_t    alu_tab [16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    endtask

    task automatic load_prog();
        debug_flag = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            in_addr_mem_inst = 32'(i) << 2;
            in_ins_to_mem    = prog[i];
            wea_ram_inst     = 1'b1;
            @(negedge clk);
        end
        wea_ram_inst = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        debug_flag = 1'b0;
    endtask

    task automatic run_to_halt(input int max, output int cyc);
        cyc = 0;
        while (!halt_flag && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check("halt_reached", 32'(halt_flag), 32'h1);
    endtask

    task automatic rd_reg(input int idx, output logic [31:0] v);
        in_addr_debug = 32'(idx);
        #1;
        v = out_reg1_recolector;
    endtask

    task automatic rd_mem(input int idx, output logic [31:0] v);
        in_addr_debug = 32'(idx);
        #1;
        v = out_mem_wire;
    endtask

    task automatic check_alu_regs(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            rd_reg(alu_tab[i].idx, v);
            check($sformatf("%s_r%0d", tag, alu_tab[i].idx), v, alu_tab[i].exp);
        end
    endtask

    task automatic load_mem_prog();
        clear_prog();
        prog[0] = 32'h2401002A;
        prog[1] = 32'hAC010008;
        prog[2] = 32'h8C030008;
        prog[3] = 32'h00632021;
        prog[4] = 32'hFFFFFFFF;
        load_prog();
    endtask

    task automatic load_alu_prog();
        clear_prog();
        prog[0]  = 32'h3C011234;
        prog[1]  = 32'h34215678;
        prog[2]  = 32'h2402FFFF;
        prog[3]  = 32'h3043F0F0;
        prog[4]  = 32'h3824FFFF;
        prog[5]  = 32'h00012823;
        prog[6]  = 32'h0040302A;
        prog[7]  = 32'h2827FFFF;
        prog[8]  = 32'h00014100;
        prog[9]  = 32'h00024F02;
        prog[10] = 32'h00235024;
        prog[11] = 32'h00695825;
        prog[12] = 32'h00416026;
        prog[13] = 32'h14C00002;
        prog[14] = 32'h240D0001;
        prog[15] = 32'h240D0002;
        prog[16] = 32'h08000014;
        prog[17] = 32'h240E0001;
        prog[18] = 32'h240E0002;
        prog[20] = 32'h00857821;
        prog[21] = 32'h24000007;
        prog[22] = 32'hFFFFFFFF;
        load_prog();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] v;

        alu_tab = '{
            '{1,  32'h12345678}, '{2,  32'hFFFFFFFF},
            '{3,  32'h0000F0F0}, '{4,  32'h1234A987},
            '{5,  32'hEDCBA988}, '{6,  32'h00000001},
            '{7,  32'h00000000}, '{8,  32'h23456780},
            '{9,  32'h0000000F}, '{10, 32'h00005070},
            '{11, 32'h0000F0FF}, '{12, 32'hEDCBA987},
            '{13, 32'h00000000}, '{14, 32'h00000000},
            '{15, 32'h0000530F}, '{0,  32'h00000000}
        };

        reset            = 1'b0;
        debug_flag       = 1'b1;
        wea_ram_inst     = 1'b0;
        in_addr_debug    = 32'h0;
        in_addr_mem_inst = 32'h0;
        in_ins_to_mem    = 32'h0;

        // Reset state, then free-running NOPs
        clear_prog();
        load_prog();
        reset = 1'b1;
        #1;
        check("rst_pc", out_pc, 32'h0);
        check("rst_l12", Latches_1_2, 32'h0);
        check("rst_l23", Latches_2_3, 32'h0);
        check("rst_l34", Latches_3_4, 32'h0);
        check("rst_l45", Latches_4_5, 32'h0);
        check("rst_halt", 32'(halt_flag), 32'h0);
        @(negedge clk);
        debug_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("nop_pc12", out_pc, 32'd12);

        // Forwarding
        clear_prog();
        prog[0] = 32'h24010005;
        prog[1] = 32'h24220007;
        prog[2] = 32'hFFFFFFFF;
        load_prog();
        restart();
        run_to_halt(100, cyc);
        check("fwd_cycles", 32'(cyc), 32'd6);
        rd_reg(1, v);
        check("fwd_r1", v, 32'd5);
        rd_reg(2, v);
        check("fwd_r2", v, 32'd12);
        check("fwd_pc", out_pc, 32'd12);

        // Store, load-use stall
        load_mem_prog();
        restart();
        run_to_halt(100, cyc);
        check("lu_cycles", 32'(cyc), 32'd9);
        rd_mem(2, v);
        check("lu_dmem2", v, 32'h2A);
        rd_reg(3, v);
        check("lu_r3", v, 32'h2A);
        rd_reg(4, v);
        check("lu_r4", v, 32'h54);
        check("lu_pc", out_pc, 32'd20);
        repeat (3) @(negedge clk);
        check("halt_frozen_pc", out_pc, 32'd20);
        check("halt_frozen_l45", Latches_4_5, 32'h0);

        // Taken branch flushes two slots
        clear_prog();
        prog[0] = 32'h10000001;
        prog[1] = 32'h24050009;
        prog[2] = 32'h24060003;
        prog[3] = 32'hFFFFFFFF;
        load_prog();
        restart();
        run_to_halt(100, cyc);
        check("br_cycles", 32'(cyc), 32'd8);
        rd_reg(5, v);
        check("br_r5", v, 32'h0);
        rd_reg(6, v);
        check("br_r6", v, 32'h3);
        check("br_pc", out_pc, 32'd16);

        // ALU ops, BNE, J, $0 write
        load_alu_prog();
        restart();
        run_to_halt(200, cyc);
        check("alu_cycles", 32'(cyc), 32'd24);
        check_alu_regs("alu");
        check("alu_pc", out_pc, 32'd92);

        // Debug freeze mid-run
        @(negedge clk);
        restart();
        repeat (8) @(negedge clk);
        debug_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("frz%0d_pc", i), out_pc, 32'd32);
            check($sformatf("frz%0d_l12", i), Latches_1_2, 32'h2827FFFF);
            check($sformatf("frz%0d_l23", i), Latches_2_3, 32'h0040302A);
            check($sformatf("frz%0d_l34", i), Latches_3_4, 32'hEDCBA988);
            check($sformatf("frz%0d_l45", i), Latches_4_5, 32'h1234A987);
        end
        debug_flag = 1'b0;
        run_to_halt(200, cyc);
        check_alu_regs("frz");
        check("frz_pc", out_pc, 32'd92);

        // Asynchronous reset mid-run
        load_mem_prog();
        restart();
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mrst_pc", out_pc, 32'h0);
        check("mrst_l12", Latches_1_2, 32'h0);
        check("mrst_l23", Latches_2_3, 32'h0);
        check("mrst_l34", Latches_3_4, 32'h0);
        check("mrst_l45", Latches_4_5, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_to_halt(100, cyc);
        check("mrst_cycles", 32'(cyc), 32'd9);
        rd_reg(4, v);
        check("mrst_r4", v, 32'h54);
        rd_mem(2, v);
        check("mrst_dmem2", v, 32'h2A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_top.md
# mips_top

Five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with on-chip instruction and data memories. It is the top of the processor and sits under the debug unit. The debug unit loads programs, freezes execution, reads registers and data memory, and watches the PC, the pipeline latches and halt status.

## Interface
- No parameters. Fixed sizes: IMEM 64×32, DMEM 32×32, register file 32×32.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `debug_flag` in 1: 1 freezes the pipeline and enables IMEM writes.
- `in_addr_debug` in 32: bits [4:0] select the register and the DMEM word for debug reads.
- `in_addr_mem_inst` in 32: IMEM byte address for loading; word index [7:2].
- `in_ins_to_mem` in 32: instruction word to load.
- `wea_ram_inst` in 1: IMEM write enable; effective only while `debug_flag`=1.
- `out_reg1_recolector` out 32: register[`in_addr_debug[4:0]`], combinational.
- `out_mem_wire` out 32: DMEM[`in_addr_debug[4:0]`], combinational.
- `out_pc` out 32: current PC (byte address).
- `halt_flag` out 1: sticky; high once HALT retires.
- `Latches_1_2` out 32: IF/ID instruction.
- `Latches_2_3` out 32: ID/EX instruction.
- `Latches_3_4` out 32: EX/MEM ALU result.
- `Latches_4_5` out 32: MEM/WB write-back data.

## Operation
- **Instruction set**, standard MIPS encodings:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLL, SRL.
  - I-type: ADDIU, ANDI, ORI, XORI, LUI, SLTI, LW, SW, BEQ, BNE.
  - Jump: J.
  - HALT = 32'hFFFF_FFFF.
  - 32'h0 and any unsupported opcode act as NOP (no writes).
- **Immediates**: sign-extended for ADDIU, SLTI, LW, SW, BEQ, BNE; zero-extended for ANDI, ORI, XORI. All arithmetic is 32-bit wrap-around; SLT and SLTI are signed.
- **PC**:
  - Increments by 4 per cycle.
  - IMEM is indexed by PC[7:2], so it wraps modulo 64 words.
  - J is resolved in ID: PC ← {PC+4[31:28], target, 2'b00}; IF/ID is flushed (1 bubble).
  - BEQ/BNE are resolved in EX on forwarded operands. When taken, PC ← PC+4+(sext(imm)<<2), and IF/ID and ID/EX are flushed (2 bubbles).
  - There is no delay slot.
- **DMEM**: word-addressed by ALU result [6:2]. SW writes at the clock edge in MEM; LW reads in MEM.
- **Register file**:
  - $0 always reads 0.
  - Written at WB.
  - A same-cycle ID read of the register being written returns the new value (write-through).
- **Forwarding** into EX: EX/MEM takes priority over MEM/WB.
- **Load-use**: if the instruction in ID needs the destination of an LW in EX, hold PC and IF/ID for 1 cycle and insert a bubble into ID/EX.
- **HALT**:
  - When decoded in ID, the PC stops advancing and bubbles are fetched after it.
  - When HALT reaches MEM/WB, `halt_flag` goes to 1.
  - While `halt_flag`=1, all state is frozen until reset.
- **Debug** (`debug_flag`=1):
  - PC, pipeline latches, register file and DMEM do not update.
  - IMEM[`in_addr_mem_inst[7:2]`] ← `in_ins_to_mem` at the edge when `wea_ram_inst`=1.
  - Debug reads are always live.
- **Reset** (`reset`=0), asynchronous:
  - PC = 0; all latches = 0 (NOP); register file = 0; `halt_flag` = 0.
  - IMEM and DMEM retain their contents.
  - Reset mid-run discards in-flight instructions.

## Timing
- An instruction fetched in cycle n writes back at the end of cycle n+4.
- Outputs `out_pc`, `Latches_*` and `halt_flag` are registered.
- Outputs `out_reg1_recolector` and `out_mem_wire` are combinational from `in_addr_debug`.
- Priority: reset > `halt_flag` freeze > debug freeze > load-use stall > branch/jump redirect.
- An IMEM write and a fetch from the same word in the same cycle cannot occur, because fetch is frozen while debug is active.

## Structure
- Shared package holds:
  - Opcode and funct constants.
  - HALT and NOP words.
  - ALU-op enumeration.
- Natural sub-modules:
  - `mips_alu`: combinational, 32-bit ALU.
  - Register file.
  - Control and hazard unit.
- Memories are inline arrays.

## Test plan
- **Reset**: hold `reset`=0, then release → `out_pc`=0, all `Latches_*`=0, `halt_flag`=0; after 3 free cycles with an empty IMEM, `out_pc`=12.
- **Forwarding**:
  - Load `ADDIU $1,$0,5`; `ADDIU $2,$1,7`; HALT via debug, then release.
  - → `halt_flag`=1; `$1`=5 and `$2`=12 via `out_reg1_recolector`.
- **Memory and load-use**:
  - Program: `ADDIU $1,$0,0x2A`; `SW $1,8($0)`; `LW $3,8($0)`; `ADDU $4,$3,$3`; HALT.
  - → `out_mem_wire` at index 2 = 0x2A; `$4`=0x54; PC holds for exactly one extra cycle.
- **Branch flush**:
  - Program: `BEQ $0,$0,+1`; `ADDIU $5,$0,9`; `ADDIU $6,$0,3`; HALT.
  - → `$5`=0, `$6`=3.
- **Debug freeze**: raise `debug_flag` mid-run for 4 cycles → `out_pc` and `Latches_*` are constant; execution resumes with identical final register values.
- **Reset mid-run**: assert `reset` asynchronously mid-run → PC=0 immediately; after release the program reruns from IMEM unchanged.
